// File: rtl/bit_enum.sv
// bit_enum: loads a vector and emits the positions of its "set" bits, lowest first.
// Optional macro BIT_ENUM_CNT_EN enables out_cnt (remaining set bits); otherwise out_cnt is tied to 0.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

module bit_enum #(
    parameter int   IN  = 128,
    parameter logic ACT = `HIGH,
    parameter int   OUT = (IN == 1) ? 1 : $clog2(IN),
    parameter int   CNT = $clog2(IN) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT-1:0] out_idx,
    output logic           out_last,
    output logic [CNT-1:0] out_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [IN-1:0]  mask;
    logic [IN-1:0]  load_mask;
    logic [IN-1:0]  rest_mask;
    logic [OUT-1:0] idx_q;
    logic           last_q;

    function automatic logic [OUT-1:0] lowest_idx(input logic [IN-1:0] m);
        logic [OUT-1:0] r;
        r = '0;
        for (int i = IN - 1; i >= 0; i--) begin
            if (m[i]) r = OUT'(i);
        end
        return r;
    endfunction

    function automatic logic single_bit(input logic [IN-1:0] m);
        return (m != '0) && ((m & (m - IN'(1))) == '0);
    endfunction

`ifdef BIT_ENUM_CNT_EN
    logic [CNT-1:0] cnt_q;

    function automatic logic [CNT-1:0] popcount(input logic [IN-1:0] m);
        logic [CNT-1:0] c;
        c = '0;
        for (int i = 0; i < IN; i++) begin
            c = c + CNT'(m[i]);
        end
        return c;
    endfunction
`endif

    // Mask of "set" bits in the offered vector, and the mask left after the current index is taken.
    assign load_mask = (ACT == `HIGH) ? in : ~in;
    assign rest_mask = mask & (mask - IN'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mask   <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
`ifdef BIT_ENUM_CNT_EN
            cnt_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // An all-zero vector is dropped without leaving IDLE.
                    if (in_valid && (load_mask != '0)) begin
                        state  <= RUN;
                        mask   <= load_mask;
                        idx_q  <= lowest_idx(load_mask);
                        last_q <= single_bit(load_mask);
`ifdef BIT_ENUM_CNT_EN
                        cnt_q  <= popcount(load_mask);
`endif
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        mask   <= rest_mask;
                        idx_q  <= lowest_idx(rest_mask);
                        last_q <= single_bit(rest_mask);
`ifdef BIT_ENUM_CNT_EN
                        cnt_q  <= popcount(rest_mask);
`endif
                        if (last_q) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RUN);
    assign out_idx   = idx_q;
    assign out_last  = last_q;

`ifdef BIT_ENUM_CNT_EN
    assign out_cnt = cnt_q;
`else
    assign out_cnt = '0;
`endif

endmodule
